bsg_then_ready_link_round_robin_masked: RTL
===========================================

// Module: bsg_then_ready_link_round_robin_masked
// PURPOSE
// N-way striping concentrator for the NoC I/O link datapath. It generalises the static 2-way round robin.
// TX: one wide then-ready stream is striped packet-by-packet across up to num_links_p physical links.
// RX: the links are merged back in the same strict rotation, so packet order is preserved end to end.
// A runtime enable mask lets dead or disabled DDR links be skipped without a respin.
// It also keeps per-link packet counters and a sticky protocol-error flag for bring-up.
// PARAMETERS
// width_p          32   packet width on every link and on the single stream
// num_links_p      4    number of physical links (>=1)
// default_mask_p   '1   enable mask applied at reset (num_links_p bits)
// count_width_p    16   width of each per-link saturating packet counter
// PORTS
// clk_i             in   1                          core (NoC) clock
// reset_n_i         in   1                          async active-low reset
// cfg_mask_i        in   num_links_p                new enable mask, sampled on cfg_update_i
// cfg_update_i      in   1                          1-cycle strobe: load mask, restart rotation, clear stats
// single_v_i        in   1                          TX stream valid
// single_data_i     in   width_p                    TX stream data
// single_ready_and_o out 1                          TX stream ready (ready-and)
// links_v_o         out  num_links_p                per-link TX valid
// links_data_o      out  num_links_p*width_p        per-link TX data (single_data_i broadcast)
// links_ready_and_i in   num_links_p                per-link TX ready
// links_v_i         in   num_links_p                per-link RX valid
// links_data_i      in   num_links_p*width_p        per-link RX data
// links_yumi_o      out  num_links_p                per-link RX dequeue
// single_v_o        out  1                          merged RX valid
// single_data_o     out  width_p                    merged RX data
// single_yumi_i     in   1                          merged RX dequeue (only when single_v_o=1)
// tx_count_o        out  num_links_p*count_width_p  packets sent per link
// rx_count_o        out  num_links_p*count_width_p  packets received per link
// error_o           out  1                          sticky: valid seen on a disabled link
// BEHAVIOUR
// - State: mask_r, tx_ptr_r, rx_ptr_r (each clog2(num_links_p) bits, constant 0 if N=1), counters, error_r.
// - Reset (async, reset_n_i=0): mask_r=default_mask_p (all-zero is forced to 1 on link 0).
//   Both pointers are set to the lowest set bit of mask_r; counters=0; error_r=0.
//   All outputs are combinational from state plus inputs, so while reset is low and inputs are idle
//   the outputs are links_v_o=0, links_yumi_o=0, single_v_o=0, counts=0, error_o=0.
// - TX (0 latency): links_v_o[tx_ptr_r]=single_v_i and all other bits are 0.
//   single_ready_and_o=links_ready_and_i[tx_ptr_r]. A handshake is single_v_i & single_ready_and_o.
// - RX (0 latency): single_v_o=links_v_i[rx_ptr_r]; single_data_o=links_data_i[rx_ptr_r].
//   links_yumi_o[rx_ptr_r]=single_yumi_i and all other bits are 0.
// - Advance: after a handshake the pointer moves to the next set bit of mask_r above it, wrapping
//   to the lowest set bit. With a single enabled link the pointer stays put. TX and RX advance independently.
// - Counters: tx_count[tx_ptr_r]++ on a TX handshake; rx_count[rx_ptr_r]++ on single_yumi_i.
//   Both saturate at all-ones and never wrap.
// - error_r <= 1 if any links_v_i[i] & ~mask_r[i] in a cycle. Sticky until reset or cfg_update_i.
// - cfg_update_i (takes effect on the next edge):
//   mask_r <= cfg_mask_i, with 0 forced to 4'b..01. Both pointers go to the lowest set bit of the new mask.
//   All counters and error_r clear. Update has priority over pointer advance and counter increment.
//   A handshake occurring in the same cycle still completes on the wire but is not counted.
// - The link partner must apply an identical update at the same stream boundary; this block does not
//   check that. Software quiesces traffic first.
// - Disabled links: links_v_o and links_yumi_o are held at 0 and their ready/valid inputs are ignored
//   for datapath purposes.
// TESTING
// 1. N=4, mask 1111, 8 back-to-back TX packets 0..7, all ready -> links get 0/4, 1/5, 2/6, 3/7;
//    tx_count={2,2,2,2}.
// 2. mask 1011 via cfg_update_i, 6 packets -> link order 0,1,3,0,1,3; link2 never valid; rx merge
//    reproduces 0..5 in order.
// 3. links_ready_and_i[1]=0 for 5 cycles while tx_ptr=1 -> single_ready_and_o=0, no pointer move,
//    no other link valid; resumes on 1 when ready returns.
// 4. cfg_mask_i=0000 + update -> only link 0 enabled; every packet goes to link 0, ptr stays 0.
// 5. mask 0111, drive links_v_i[3]=1 one cycle -> error_o=1 next cycle, stays 1; cfg_update_i clears it.
// 6. Preload tx_count[0]=all-ones (count_width_p=4, 16 pkts, mask 0001) -> count holds 15; assert reset_n_i
//    mid-burst -> all counts 0, ptrs 0, mask=default.

Source files
------------

// File: rtl/bsg_then_ready_link_round_robin_masked.sv
// N-way striping concentrator for the NoC I/O link datapath.
// TX stripes one then-ready stream packet-by-packet across the enabled links.
// RX merges the links back in the same strict rotation, which preserves packet order.
// A runtime enable mask skips dead links. Per-link saturating counters and a sticky
// protocol-error flag support bring-up.
module bsg_then_ready_link_round_robin_masked #(
  parameter int                     width_p        = 32,
  parameter int                     num_links_p    = 4,
  parameter logic [num_links_p-1:0] default_mask_p = '1,
  parameter int                     count_width_p  = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_links_p-1:0]               cfg_mask_i,
  input  logic                                 cfg_update_i,
  input  logic                                 single_v_i,
  input  logic [width_p-1:0]                   single_data_i,
  output logic                                 single_ready_and_o,
  output logic [num_links_p-1:0]               links_v_o,
  output logic [num_links_p*width_p-1:0]       links_data_o,
  input  logic [num_links_p-1:0]               links_ready_and_i,
  input  logic [num_links_p-1:0]               links_v_i,
  input  logic [num_links_p*width_p-1:0]       links_data_i,
  output logic [num_links_p-1:0]               links_yumi_o,
  output logic                                 single_v_o,
  output logic [width_p-1:0]                   single_data_o,
  input  logic                                 single_yumi_i,
  output logic [num_links_p*count_width_p-1:0] tx_count_o,
  output logic [num_links_p*count_width_p-1:0] rx_count_o,
  output logic                                 error_o
);

  localparam int ptr_w_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1;

  // An all-zero mask would leave nothing to rotate over, so link 0 stays enabled.
  function automatic logic [num_links_p-1:0] sanitize_mask(input logic [num_links_p-1:0] m);
    logic [num_links_p-1:0] one_v;
    one_v    = '0;
    one_v[0] = 1'b1;
    if (m == '0) begin
      return one_v;
    end else begin
      return m;
    end
  endfunction

  // Index of the lowest enabled link; the mask is always nonzero here.
  function automatic logic [ptr_w_lp-1:0] lowest_set(input logic [num_links_p-1:0] m);
    logic [ptr_w_lp-1:0] r;
    logic                found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < num_links_p; i++) begin
      if (m[i] && !found) begin
        r     = ptr_w_lp'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  // Next enabled link above p, wrapping; returns p when it is the only enabled link.
  function automatic logic [ptr_w_lp-1:0] next_set(input logic [num_links_p-1:0] m,
                                                   input logic [ptr_w_lp-1:0]    p);
    logic [ptr_w_lp-1:0] r;
    logic                found;
    int                  idx;
    r     = p;
    found = 1'b0;
    for (int i = 1; i < num_links_p; i++) begin
      idx = (int'(p) + i) % num_links_p;
      if (m[idx] && !found) begin
        r     = ptr_w_lp'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] c);
    if (c == {count_width_p{1'b1}}) begin
      return c;
    end else begin
      return c + {{(count_width_p-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [num_links_p-1:0]                    mask_r;
  logic [ptr_w_lp-1:0]                       tx_ptr_r;
  logic [ptr_w_lp-1:0]                       rx_ptr_r;
  logic [num_links_p-1:0][count_width_p-1:0] tx_cnt_r;
  logic [num_links_p-1:0][count_width_p-1:0] rx_cnt_r;
  logic                                      error_r;

  logic [num_links_p-1:0][width_p-1:0]       rx_data_s;
  logic [num_links_p-1:0]                    new_mask_s;
  logic                                      tx_hs_s;
  logic                                      err_hit_s;

  assign rx_data_s  = links_data_i;
  assign new_mask_s = sanitize_mask(cfg_mask_i);
  assign tx_hs_s    = single_v_i & links_ready_and_i[tx_ptr_r];
  assign err_hit_s  = |(links_v_i & ~mask_r);

  // TX steering: only the link under the pointer sees the stream valid.
  always_comb begin
    links_v_o           = '0;
    links_v_o[tx_ptr_r] = single_v_i;
    single_ready_and_o  = links_ready_and_i[tx_ptr_r];
    links_data_o        = {num_links_p{single_data_i}};
  end

  // RX merge: present the link under the pointer and route the dequeue back to it.
  always_comb begin
    links_yumi_o           = '0;
    links_yumi_o[rx_ptr_r] = single_yumi_i;
    single_v_o             = links_v_i[rx_ptr_r];
    single_data_o          = rx_data_s[rx_ptr_r];
  end

  // Mask and rotation pointers; an update restarts both rotations.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mask_r   <= sanitize_mask(default_mask_p);
      tx_ptr_r <= lowest_set(sanitize_mask(default_mask_p));
      rx_ptr_r <= lowest_set(sanitize_mask(default_mask_p));
    end else if (cfg_update_i) begin
      mask_r   <= new_mask_s;
      tx_ptr_r <= lowest_set(new_mask_s);
      rx_ptr_r <= lowest_set(new_mask_s);
    end else begin
      if (tx_hs_s) begin
        tx_ptr_r <= next_set(mask_r, tx_ptr_r);
      end else begin
        tx_ptr_r <= tx_ptr_r;
      end
      if (single_yumi_i) begin
        rx_ptr_r <= next_set(mask_r, rx_ptr_r);
      end else begin
        rx_ptr_r <= rx_ptr_r;
      end
    end
  end

  // Per-link packet counters; an update clears them and suppresses same-cycle counts.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_cnt_r <= '0;
      rx_cnt_r <= '0;
    end else if (cfg_update_i) begin
      tx_cnt_r <= '0;
      rx_cnt_r <= '0;
    end else begin
      if (tx_hs_s) begin
        tx_cnt_r[tx_ptr_r] <= sat_inc(tx_cnt_r[tx_ptr_r]);
      end else begin
        tx_cnt_r <= tx_cnt_r;
      end
      if (single_yumi_i) begin
        rx_cnt_r[rx_ptr_r] <= sat_inc(rx_cnt_r[rx_ptr_r]);
      end else begin
        rx_cnt_r <= rx_cnt_r;
      end
    end
  end

  // Sticky error: a partner driving valid on a link we have disabled.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_r <= 1'b0;
    end else if (cfg_update_i) begin
      error_r <= 1'b0;
    end else if (err_hit_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign tx_count_o = tx_cnt_r;
  assign rx_count_o = rx_cnt_r;
  assign error_o    = error_r;

endmodule
